btn_conditioner: RTL
====================

Name: btn_conditioner

Overview:
- Per-button input conditioner for the board push-buttons: 2-FF synchronizer, tick-sampled debounce, one-cycle press/release strobes, and typematic auto-repeat.
- Sits directly upstream of the generic enable/terminal-count counters: btn_step[i] drives a counter's enable input, so one physical press yields exactly one increment (plus repeats while held).
- Single clock domain; raw pad inputs are asynchronous.

Parameters:
- N_BTN, 5, number of independent button channels.
- TICK_DIV, 100000, clk cycles per sample tick (1 ms at 100 MHz); legal range is 1 or more.
- DB_TICKS, 10, consecutive ticks of stable level required to accept a change; legal range is 1 or more.
- RPT_DELAY, 500, ticks held before the first repeat; 0 disables auto-repeat.
- RPT_RATE, 100, ticks between subsequent repeats; legal range is 1 or more.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- btn_raw  in  N_BTN  raw asynchronous button pads, 1 = pressed.
- btn_level  out  N_BTN  debounced level.
- btn_press  out  N_BTN  one-cycle strobe on the accepted press.
- btn_release  out  N_BTN  one-cycle strobe on the accepted release.
- btn_step  out  N_BTN  one-cycle strobe equal to press OR repeat; feeds a counter enable.

Behaviour:
- Reset (async, active-high):
  - synchronizer FFs, prescaler, all channel counters and all outputs go to 0.
  - every FSM goes to RELEASED.
  - On rst deassert with a button already held: no strobe is emitted; the full debounce must elapse before a press is accepted.
- Synchronizer: 2 flops per bit; sync[i] lags btn_raw[i] by 2 clk.
- Prescaler:
  - shared counter runs 0..TICK_DIV-1 and wraps.
  - tick is high for one clk when count == TICK_DIV-1.
  - TICK_DIV=1 gives tick every cycle.
- Channel FSM (per bit, fully independent). Each channel has a debounce count dcnt and a repeat count rcnt.
  - RELEASED: sync=1 -> PRESS_PEND, dcnt=0.
  - PRESS_PEND:
    - sync=0 -> RELEASED (glitch rejected, no strobe).
    - tick with sync=1 -> dcnt++.
    - On the tick that makes dcnt reach DB_TICKS -> PRESSED, rcnt=0.
  - PRESSED:
    - sync=0 -> RELEASE_PEND, dcnt=0.
    - Else on tick, if RPT_DELAY>0: rcnt++. When rcnt reaches RPT_DELAY, emit a repeat, then reload so the next repeat fires RPT_RATE ticks later, periodically.
  - RELEASE_PEND:
    - sync=1 -> PRESSED; rcnt is held, no strobe.
    - tick with sync=0 -> dcnt++.
    - On the tick reaching DB_TICKS -> RELEASED.
- Priority: a sync level change in the same cycle as tick wins; the count restarts and that tick is not counted.
- Outputs are registered:
  - btn_level=1 exactly while the FSM is in PRESSED or RELEASE_PEND.
  - btn_press is high for the single clk in which btn_level first goes 1.
  - btn_release is high for the single clk in which btn_level first goes 0.
  - Repeat strobes occur only in PRESSED and never coincide with btn_press.
  - btn_step = press | repeat.
- Latency, raw edge to btn_level change: between 2+(DB_TICKS-1)*TICK_DIV+1 and 2+DB_TICKS*TICK_DIV+1 clk.
- Counter widths: dcnt is clog2(DB_TICKS+1) bits; rcnt is clog2(max(RPT_DELAY,RPT_RATE)+1) bits. No overflow is possible because counts saturate by state transition.
- Simultaneous events: multiple channels may strobe in the same cycle; no arbitration.
- Reset mid-press aborts silently: no release strobe is emitted.

Decomposition:
- Shared package/header:
  - state encodings RELEASED=2'd0, PRESS_PEND=2'd1, PRESSED=2'd2, RELEASE_PEND=2'd3.
  - clog2 constant function.
- Top level: holds the synchronizer and the single prescaler.
- Sub-module btn_channel: one FSM with dcnt/rcnt; takes clk, rst, tick, sync and produces level, press, release, step. Instantiated N_BTN times via generate.

Test Plan (bench uses TICK_DIV=4, DB_TICKS=3, RPT_DELAY=5, RPT_RATE=2, N_BTN=2):
- Clean press: btn_raw[0] 0->1 held -> btn_level[0] rises between 11 and 15 clk after the edge; btn_press[0]=btn_step[0]=1 for exactly 1 clk at that cycle; channel 1 stays 0.
- Bounce: btn_raw[0] toggles every 3 clk for 40 clk, then holds 1 -> zero strobes during bouncing; exactly one btn_press after the hold satisfies debounce.
- Auto-repeat: hold btn_raw[0] for 60 clk after acceptance -> btn_step pulses at 5 ticks (~20 clk) after press, then every 8 clk; btn_press only once; btn_release=0 throughout.
- Release with glitch: after press, drop btn_raw to 0 for 5 clk then back to 1 -> no release strobe, btn_level stays 1, repeat cadence continues; a final sustained 0 gives one btn_release pulse and btn_level=0.
- Reset mid-operation: assert rst while in PRESSED and while btn_raw is held -> all outputs 0 immediately (async); after deassert, no strobe until a full debounce, then one btn_press.
- Parallel channels: both btn_raw bits rise in the same cycle -> btn_press[1:0]=2'b11 in the same clk.

Source files
------------

// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: channel FSM encoding and
// elaboration-time sizing helpers.
package btn_conditioner_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_t;

  // Bits needed to represent values 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: tick-sampled debounce FSM with press/release strobes and
// typematic repeat. All outputs are registered.
module btn_channel
  import btn_conditioner_pkg::*;
#(
  parameter int DB_TICKS  = 10,
  parameter int RPT_DELAY = 500,
  parameter int RPT_RATE  = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sync,
  output logic level,
  output logic press,
  output logic rel,
  output logic step
);

  localparam int DW = clog2(DB_TICKS + 1);
  localparam int RW = clog2(max2(RPT_DELAY, RPT_RATE) + 1);
  localparam bit RPT_EN = (RPT_DELAY > 0);
  localparam logic [DW-1:0] DB_LAST    = DW'(DB_TICKS - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(RPT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(RPT_RATE - 1);

  btn_state_t state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic rphase_q, rphase_d;  // 0: waiting out the initial delay, 1: periodic repeat
  logic rpt_hit;
  logic level_d, press_d, rel_d, step_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RELEASED;
      dcnt_q   <= '0;
      rcnt_q   <= '0;
      rphase_q <= 1'b0;
      level    <= 1'b0;
      press    <= 1'b0;
      rel      <= 1'b0;
      step     <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      rcnt_q   <= rcnt_d;
      rphase_q <= rphase_d;
      level    <= level_d;
      press    <= press_d;
      rel      <= rel_d;
      step     <= step_d;
    end
  end

  // A level change always takes precedence over a coincident tick.
  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    rcnt_d   = rcnt_q;
    rphase_d = rphase_q;
    rpt_hit  = 1'b0;
    case (state_q)
      RELEASED: begin
        if (sync) begin
          state_d = PRESS_PEND;
          dcnt_d  = '0;
        end
      end
      PRESS_PEND: begin
        if (!sync) begin
          state_d = RELEASED;
        end else if (tick) begin
          if (dcnt_q == DB_LAST) begin
            state_d  = PRESSED;
            rcnt_d   = '0;
            rphase_d = 1'b0;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_d = RELEASE_PEND;
          dcnt_d  = '0;
        end else if (tick && RPT_EN) begin
          if (rcnt_q == (rphase_q ? RATE_LAST : DELAY_LAST)) begin
            rpt_hit  = 1'b1;
            rcnt_d   = '0;
            rphase_d = 1'b1;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
      end
      RELEASE_PEND: begin
        if (sync) begin
          state_d = PRESSED;
        end else if (tick) begin
          if (dcnt_q == DB_LAST) begin
            state_d = RELEASED;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  always_comb begin
    level_d = (state_d == PRESSED) || (state_d == RELEASE_PEND);
    press_d = (state_q == PRESS_PEND) && (state_d == PRESSED);
    rel_d   = (state_q == RELEASE_PEND) && (state_d == RELEASED);
    step_d  = press_d || rpt_hit;
  end

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-FF synchronizer and shared sample-tick prescaler
// feeding one independent debounce/repeat channel per button.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int N_BTN     = 5,
  parameter int TICK_DIV  = 100000,
  parameter int DB_TICKS  = 10,
  parameter int RPT_DELAY = 500,
  parameter int RPT_RATE  = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_step
);

  localparam int PW = clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [N_BTN-1:0] meta;
  logic [N_BTN-1:0] sync;
  logic [PW-1:0]    pre_cnt;
  logic             tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= btn_raw;
      sync <= meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  assign tick = (pre_cnt == PRE_LAST);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DB_TICKS (DB_TICKS),
      .RPT_DELAY(RPT_DELAY),
      .RPT_RATE (RPT_RATE)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .sync (sync[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i]),
      .step (btn_step[i])
    );
  end

endmodule
